// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared constants and pipeline-stage type for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int DEF_NUM_PORTS  = 4;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MAX_WORD   = 100;
    localparam int WORD_SHIFT     = 2;

    // Port field sized for the largest supported requester count.
    localparam int MAX_PORTS  = 8;
    localparam int PORT_IDX_W = $clog2(MAX_PORTS);

    typedef struct packed {
        logic                  valid;
        logic [PORT_IDX_W-1:0] port;
        logic                  read;
        logic                  oor;
    } pipe_stage_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first request at or above ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int IDX_W     = $clog2(DEF_NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 gnt_valid
);

    int idx;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(ptr) + k) % NUM_PORTS;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(idx);
                gnt[idx]  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin sharing of one single-port RAM with pipelined reads.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_WORD   = DEF_MAX_WORD
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req_valid,
    output logic [NUM_PORTS-1:0]             req_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_PORTS-1:0]             req_w_rq,
    output logic [NUM_PORTS-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic [NUM_PORTS-1:0]             err_sticky,
    input  logic [NUM_PORTS-1:0]             err_clear,
    output logic [ADDR_WIDTH-1:0]            ram_addr,
    output logic [DATA_WIDTH-1:0]            ram_data_in,
    output logic                             ram_w_rq,
    input  logic [DATA_WIDTH-1:0]            ram_data_out
);

    localparam int                    IDX_W      = $clog2(NUM_PORTS);
    localparam logic [ADDR_WIDTH-1:0] MAX_WORD_A = ADDR_WIDTH'(MAX_WORD);

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
            assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic [NUM_PORTS-1:0] gnt;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 gnt_valid;

    logic [IDX_W-1:0]      ptr_q, ptr_d;
    pipe_stage_t           s1_q, s1_d, s2_q, s2_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_data_in_q, ram_data_in_d;
    logic                  ram_w_rq_q, ram_w_rq_d;
    logic [NUM_PORTS-1:0]  err_q, err_d;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  in_range;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Grants are masked while reset is held so nothing looks accepted.
    assign req_ready = reset ? '0 : gnt;

    always_comb begin
        ptr_d         = ptr_q;
        s1_d          = '0;
        s2_d          = s1_q;
        ram_addr_d    = ram_addr_q;
        ram_data_in_d = ram_data_in_q;
        ram_w_rq_d    = 1'b0;
        err_d         = err_q & ~err_clear;
        sel_addr      = addr_arr[gnt_idx];
        in_range      = (sel_addr >> WORD_SHIFT) <= MAX_WORD_A;
        if (gnt_valid) begin
            ptr_d         = (gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + IDX_W'(1);
            ram_addr_d    = sel_addr;
            ram_data_in_d = wdata_arr[gnt_idx];
            ram_w_rq_d    = req_w_rq[gnt_idx] & in_range;
            s1_d.valid    = 1'b1;
            s1_d.port     = PORT_IDX_W'(gnt_idx);
            s1_d.read     = ~req_w_rq[gnt_idx];
            s1_d.oor      = ~in_range;
            // A new error beats a same-cycle clear.
            if (!in_range) begin
                err_d[gnt_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q         <= '0;
            s1_q          <= '0;
            s2_q          <= '0;
            ram_addr_q    <= '0;
            ram_data_in_q <= '0;
            ram_w_rq_q    <= 1'b0;
            err_q         <= '0;
        end else begin
            ptr_q         <= ptr_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_in_q <= ram_data_in_d;
            ram_w_rq_q    <= ram_w_rq_d;
            err_q         <= err_d;
        end
    end

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rsp
            assign rsp_valid[i] = s2_q.valid & s2_q.read & (s2_q.port == PORT_IDX_W'(i));
        end
    endgenerate

    assign rsp_rdata   = (s2_q.valid && s2_q.read && !s2_q.oor) ? ram_data_out : '0;
    assign err_sticky  = err_q;
    assign ram_addr    = ram_addr_q;
    assign ram_data_in = ram_data_in_q;
    assign ram_w_rq    = ram_w_rq_q;

endmodule
`default_nettype wire
